// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding,
// the byte width and the default per-grant burst limit.
package uart_tx_arbiter_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int DEFAULT_MAX_BURST = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the transmitter byte/start/busy link.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]                                   req_valid_i;
  logic [uart_tx_arbiter_pkg::UART_DATA_W*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]                                   req_last_i;
  logic [N_REQ-1:0]                                   req_ready_o;
  logic [uart_tx_arbiter_pkg::UART_DATA_W-1:0]        tx_data_o;
  logic                                               tx_start_o;
  logic                                               tx_busy_i;
  logic [N_REQ-1:0]                                   grant_o;

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_busy_i,
    output req_ready_o, tx_data_o, tx_start_o, grant_o
  );

  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_busy_i,
    input  req_ready_o, tx_data_o, tx_start_o, grant_o
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set request after ptr,
// wrapping modulo N, returned both one-hot and as an index.
module uart_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    any   = |req;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        grant = N'(1) << cand;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART transmitter among N_REQ
// byte streams; a grant ends on a last-flagged byte or after MAX_BURST bytes.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk_i,
  input  logic              rstb_i,
  uart_tx_arbiter_if.slave  bus
);

  localparam int              IDX_W       = $clog2(N_REQ);
  localparam logic [7:0]      BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [IDX_W-1:0] PTR_RESET  = IDX_W'(N_REQ - 1);

  arb_state_t             state_reg, state_next;
  logic [N_REQ-1:0]       grant_reg, grant_next;
  logic [IDX_W-1:0]       ptr_reg, ptr_next;
  logic [7:0]             burst_reg, burst_next;
  logic                   last_reg, last_next;
  logic [UART_DATA_W-1:0] tx_data_reg, tx_data_next;

  logic [UART_DATA_W-1:0] req_bytes [N_REQ];
  logic [N_REQ-1:0]       pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   accept;
  logic [N_REQ-1:0]       ready_vec;
  logic                   start_pulse;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = bus.req_data_i[gi*UART_DATA_W +: UART_DATA_W];
  end

  uart_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req_valid_i),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // While granted, ptr_reg is the owner index.
  assign accept = (state_reg == ST_FETCH) && bus.req_valid_i[ptr_reg] && !bus.tx_busy_i;

  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      ptr_reg     <= PTR_RESET;
      burst_reg   <= '0;
      last_reg    <= 1'b0;
      tx_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      burst_reg   <= burst_next;
      last_reg    <= last_next;
      tx_data_reg <= tx_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    burst_next   = burst_reg;
    last_next    = last_reg;
    tx_data_next = tx_data_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (pick_any) begin
          grant_next = pick_grant;
          ptr_next   = pick_idx;
          burst_next = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (accept) begin
          tx_data_next = req_bytes[ptr_reg];
          last_next    = bus.req_last_i[ptr_reg];
          burst_next   = burst_reg + 8'd1;
          state_next   = ST_START;
        end
      end
      ST_START: state_next = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.tx_busy_i) state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy_i) begin
          if (last_reg || (burst_reg == BURST_LIMIT)) begin
            grant_next = '0;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      default: begin
        grant_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    ready_vec   = '0;
    start_pulse = 1'b0;
    unique case (state_reg)
      ST_FETCH: if (accept) ready_vec[ptr_reg] = 1'b1;
      ST_START: start_pulse = 1'b1;
      default: ;
    endcase
  end

  assign bus.req_ready_o = ready_vec;
  assign bus.tx_start_o  = start_pulse;
  assign bus.tx_data_o   = tx_data_reg;
  assign bus.grant_o     = grant_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised and directed bench for uart_tx_arbiter with a transaction-level
// reference model, a UART transmitter stand-in and a start-pulse log.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int MB = 8;

  localparam int P_ACC   = 0;  // owner granted, waiting for its next byte
  localparam int P_PULSE = 1;  // byte accepted, start pulse due
  localparam int P_RISE  = 2;  // waiting for the frame to begin
  localparam int P_FALL  = 3;  // waiting for the frame to end

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ     (N),
    .MAX_BURST (MB)
  ) dut (
    .clk_i  (clk),
    .rstb_i (rstb),
    .bus    (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         delay;
  } item_t;

  typedef struct {
    int         owner;
    logic [3:0] g;
    logic [7:0] d;
  } log_t;

  item_t      drv_q [N][$];
  logic [8:0] exp_q [N][$];
  log_t       tx_log [$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic         ext_busy    = 1'b0;
  logic [N-1:0] ready_seen  = '0;
  logic         start_seen  = 1'b0;

  int         m_owner = -1;
  int         m_ptr   = N - 1;
  int         m_ph    = P_ACC;
  int         m_cnt   = 0;
  logic       m_last  = 1'b0;
  logic [7:0] m_txd   = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l, input int dly);
    item_t it;
    it.data  = d;
    it.last  = l;
    it.delay = dly;
    drv_q[k].push_back(it);
    exp_q[k].push_back({l, d});
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (m_owner < 0) && !bus.tx_busy_i;
    for (int k = 0; k < N; k++) if (drv_q[k].size() != 0) q = 0;
    return q;
  endfunction

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (!all_quiet() && n < maxc) begin
      next_cycle();
      n++;
    end
    chk("idle_timeout", 32'(n >= maxc), 32'd0);
    repeat (2) next_cycle();
  endtask

  task automatic wait_log(input int size, input int maxc);
    int n;
    n = 0;
    while (tx_log.size() < size && n < maxc) begin
      next_cycle();
      n++;
    end
    chk("log_timeout", 32'(n >= maxc), 32'd0);
  endtask

  task automatic chk_log(input string nm, input int idx, input int owner, input logic [7:0] d);
    if (idx < tx_log.size()) begin
      chk({nm, "_owner"}, tx_log[idx].owner, owner);
      chk({nm, "_data"}, 32'(tx_log[idx].d), 32'(d));
    end else begin
      chk({nm, "_missing"}, tx_log.size(), idx + 1);
    end
  endtask

  // Compare process: every cycle, outputs against the model, then advance it.
  initial begin
    logic [N-1:0] v, r, g, exp_g, exp_r;
    logic         s, b;
    logic [7:0]   d;
    log_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstb) begin
        m_owner    = -1;
        m_ptr      = N - 1;
        m_ph       = P_ACC;
        m_cnt      = 0;
        m_last     = 1'b0;
        m_txd      = 8'h00;
        ready_seen = '0;
        start_seen = 1'b0;
        continue;
      end
      v = bus.req_valid_i;
      r = bus.req_ready_o;
      s = bus.tx_start_o;
      g = bus.grant_o;
      b = bus.tx_busy_i;
      d = bus.tx_data_o;
      exp_g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      exp_r = (m_owner >= 0 && m_ph == P_ACC && v[m_owner] && !b) ? exp_g : '0;
      chk("grant", 32'(g), 32'(exp_g));
      chk("ready", 32'(r), 32'(exp_r));
      chk("start", 32'(s), 32'(m_owner >= 0 && m_ph == P_PULSE));
      chk("tx_data", 32'(d), 32'(m_txd));
      if (s) begin
        chk("start_while_busy", 32'(b), 32'd0);
        e.owner = -1;
        for (int k = 0; k < N; k++) if (g[k]) e.owner = k;
        e.g = g;
        e.d = d;
        tx_log.push_back(e);
      end
      ready_seen = r;
      start_seen = s;
      if (m_owner < 0) begin
        if (v != '0) begin
          int c;
          bit found;
          found = 0;
          for (int off = 1; off <= N; off++) begin
            c = (m_ptr + off) % N;
            if (!found && v[c]) begin
              m_owner = c;
              found   = 1;
            end
          end
          m_ptr = m_owner;
          m_cnt = 0;
          m_ph  = P_ACC;
        end
      end else begin
        case (m_ph)
          P_ACC: if (v[m_owner] && !b) begin
            {m_last, m_txd} = exp_q[m_owner].pop_front();
            m_cnt++;
            m_ph = P_PULSE;
          end
          P_PULSE: m_ph = P_RISE;
          P_RISE:  if (b) m_ph = P_FALL;
          default: if (!b) begin
            if (m_last || m_cnt == MB) m_owner = -1;
            else m_ph = P_ACC;
          end
        endcase
      end
    end
  end

  // Requester and transmitter stand-ins, updated just after each rising edge.
  initial begin
    int           cur_wait [N];
    int           tx_cnt;
    logic [N-1:0] vv, ll;
    logic [8*N-1:0] dv;
    for (int k = 0; k < N; k++) cur_wait[k] = -1;
    tx_cnt = 0;
    vv = '0;
    ll = '0;
    dv = '0;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.req_last_i  = '0;
    bus.tx_busy_i   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (ready_seen[k] && drv_q[k].size() > 0) begin
          void'(drv_q[k].pop_front());
          cur_wait[k] = -1;
        end
        vv[k] = 1'b0;
        if (drv_q[k].size() > 0) begin
          if (cur_wait[k] < 0) cur_wait[k] = drv_q[k][0].delay;
          if (cur_wait[k] > 0) begin
            cur_wait[k]--;
          end else begin
            vv[k]          = 1'b1;
            dv[8*k +: 8]   = drv_q[k][0].data;
            ll[k]          = drv_q[k][0].last;
          end
        end
      end
      bus.req_valid_i = vv;
      bus.req_data_i  = dv;
      bus.req_last_i  = ll;
      if (start_seen) tx_cnt = $urandom_range(5, 3);
      if (tx_cnt > 0) begin
        tx_cnt--;
        bus.tx_busy_i = 1'b1;
      end else begin
        bus.tx_busy_i = ext_busy;
      end
    end
  end

  initial begin
    int base;
    repeat (3) next_cycle();
    chk("reset_grant", 32'(bus.grant_o), 32'd0);
    chk("reset_ready", 32'(bus.req_ready_o), 32'd0);
    chk("reset_start", 32'(bus.tx_start_o), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data_o), 32'd0);
    @(posedge clk);
    #3 rstb = 1'b1;

    // Contention: 0 before 2, twice.
    for (int rnd = 0; rnd < 2; rnd++) begin
      next_cycle();
      base = tx_log.size();
      push(0, 8'hC0, 1'b1, 0);
      push(2, 8'hC2, 1'b1, 0);
      wait_idle(300);
      chk_log("contend_first", base, 0, 8'hC0);
      chk_log("contend_second", base + 1, 2, 8'hC2);
    end

    // Single requester, two-byte packet.
    base = tx_log.size();
    push(1, 8'h55, 1'b0, 0);
    push(1, 8'hA3, 1'b1, 0);
    wait_idle(300);
    chk_log("single_b0", base, 1, 8'h55);
    chk_log("single_b1", base + 1, 1, 8'hA3);
    if (tx_log.size() > base) chk("single_grant", 32'(tx_log[base].g), 32'h2);
    chk("single_grant_released", 32'(bus.grant_o), 32'd0);

    // Burst limit splits a 10-byte packet; waiting requester 0 slips in.
    base = tx_log.size();
    for (int i = 0; i < 10; i++) push(3, 8'(i), i == 9, 0);
    push(0, 8'hB0, 1'b1, 6);
    wait_idle(600);
    for (int i = 0; i < 8; i++) chk_log("burst_first", base + i, 3, 8'(i));
    chk_log("burst_other", base + 8, 0, 8'hB0);
    chk_log("burst_resume0", base + 9, 3, 8'h08);
    chk_log("burst_resume1", base + 10, 3, 8'h09);
    chk("tx_data_hold", 32'(bus.tx_data_o), 32'h09);

    // Packet lock: owner goes quiet mid-packet while requester 1 waits.
    base = tx_log.size();
    push(0, 8'h11, 1'b0, 0);
    push(0, 8'h22, 1'b1, 50);
    push(1, 8'h33, 1'b1, 0);
    wait_log(base + 1, 100);
    for (int i = 0; i < 30; i++) begin
      next_cycle();
      chk("lock_grant", 32'(bus.grant_o), 32'h1);
      chk("lock_start", 32'(bus.tx_start_o), 32'd0);
    end
    wait_idle(300);
    chk_log("lock_b0", base, 0, 8'h11);
    chk_log("lock_b1", base + 1, 0, 8'h22);
    chk_log("lock_next", base + 2, 1, 8'h33);

    // Busy interlock: no accept or start while the transmitter reports busy.
    ext_busy = 1'b1;
    repeat (3) next_cycle();
    base = tx_log.size();
    push(2, 8'h5A, 1'b1, 0);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      chk("interlock_ready", 32'(bus.req_ready_o), 32'd0);
      chk("interlock_start", 32'(bus.tx_start_o), 32'd0);
    end
    chk("interlock_grant", 32'(bus.grant_o), 32'h4);
    ext_busy = 1'b0;
    wait_idle(300);
    chk("interlock_starts", tx_log.size() - base, 32'd1);
    chk_log("interlock_byte", base, 2, 8'h5A);

    // Reset while the frame is in flight.
    base = tx_log.size();
    push(1, 8'h71, 1'b1, 0);
    wait_log(base + 1, 100);
    begin
      int n;
      n = 0;
      while (!bus.tx_busy_i && n < 20) begin
        next_cycle();
        n++;
      end
      chk("midframe_busy_timeout", 32'(n >= 20), 32'd0);
    end
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    chk("midreset_grant", 32'(bus.grant_o), 32'd0);
    chk("midreset_ready", 32'(bus.req_ready_o), 32'd0);
    chk("midreset_start", 32'(bus.tx_start_o), 32'd0);
    chk("midreset_tx_data", 32'(bus.tx_data_o), 32'd0);
    push(2, 8'h82, 1'b1, 0);
    push(1, 8'h81, 1'b1, 0);
    push(0, 8'h80, 1'b1, 0);
    repeat (3) next_cycle();
    @(posedge clk);
    #3 rstb = 1'b1;
    base = tx_log.size();
    wait_idle(400);
    chk_log("postreset_0", base, 0, 8'h80);
    chk_log("postreset_1", base + 1, 1, 8'h81);
    chk_log("postreset_2", base + 2, 2, 8'h82);

    // Random packets on all requesters.
    for (int rnd = 0; rnd < 6; rnd++) begin
      int total;
      for (int k = 0; k < N; k++) begin
        int npk;
        npk = $urandom_range(2, 0);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(12, 1);
          for (int i = 0; i < len; i++)
            push(k, 8'($urandom_range(255, 0)), i == len - 1, $urandom_range(3, 0));
        end
      end
      wait_idle(4000);
      total = 0;
      for (int k = 0; k < N; k++) total += exp_q[k].size();
      chk("random_drained", total, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (byte-in, start-pulse, busy-out) among N_REQ byte-stream requesters.
- Packet-locked round-robin arbitration: a granted requester keeps the transmitter until it sends a byte flagged last, or until MAX_BURST bytes have gone out.
- Sits between the command/status sources and the UART transmitter, mirroring how the receiver side is sequenced by its FSM.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 8, maximum bytes per grant before forced rotation (1..255).

Ports:
- clk_i, in, 1, system clock.
- rstb_i, in, 1, reset, asynchronous, active-low.
- req_valid_i, in, N_REQ, per-requester byte available.
- req_data_i, in, 8*N_REQ, per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i, in, N_REQ, byte is the last of its packet.
- req_ready_o, out, N_REQ, one-cycle accept strobe to the owner.
- tx_data_o, out, 8, registered byte to the transmitter.
- tx_start_o, out, 1, one-cycle start pulse.
- tx_busy_i, in, 1, transmitter busy (high from the cycle after start until the stop bit is done).
- grant_o, out, N_REQ, one-hot current owner; all-zero when idle.

Behaviour:
- Reset values: req_ready_o=0, tx_data_o=0, tx_start_o=0, grant_o=0, state=IDLE, burst count=0, last-grant pointer=N_REQ-1 (requester 0 wins first).
- Reset asserted mid-operation aborts immediately to these values; the transmitter finishes its own frame independently.

States:
- IDLE
  - If any req_valid_i bit is set, select the first set bit scanning from pointer+1, wrapping modulo N_REQ.
  - Register grant_o, store the pointer, clear the burst count, go to FETCH.
  - Arbitration takes 1 cycle.
- FETCH
  - Wait until req_valid_i[owner]=1 and tx_busy_i=0.
  - Then pulse req_ready_o[owner] for exactly one cycle, latch the data into tx_data_o, latch last, increment the burst count, and go to START.
  - The accept is the valid/ready handshake. The requester must hold data and last stable while valid is high, and updates on the cycle after ready.
- START
  - tx_start_o=1 for one cycle, then go to WAIT_BUSY.
- WAIT_BUSY
  - Wait for tx_busy_i=1, then go to WAIT_DONE.
- WAIT_DONE
  - Wait for tx_busy_i=0.
  - If the latched last=1, or burst count==MAX_BURST: clear grant_o and go to IDLE.
  - Otherwise go to FETCH.

Boundary and timing rules:
- Owner deasserts valid mid-packet (no last seen): grant is held indefinitely in FETCH; no other requester is serviced (packet lock).
- Burst limit reached without last: grant is released and the owner re-arbitrates later. The packet is split; the receiver side handles framing.
- Only one requester valid: it regains the grant each round with no penalty beyond the 1-cycle IDLE arbitration.
- A requester raising valid while another owns the grant waits; the pointer guarantees service within N_REQ grants.
- tx_start_o is never asserted while tx_busy_i=1.
- req_ready_o is at most one-hot and only on the owner bit.
- tx_data_o holds the last transmitted byte while idle.
- Minimum byte-to-byte spacing for the owner: the transmitter frame time plus 3 cycles (FETCH, START, WAIT_BUSY entry).

Decomposition:
- Shared package: state encoding (IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE), the byte-width constant UART_DATA_W=8, and the default MAX_BURST.
- One sub-module: uart_rr_pick. Combinational round-robin priority selector taking the N_REQ request vector and pointer, returning a one-hot grant and an index. It is reusable by the receive-side dispatcher.

Test Plan:
- Single requester: req 1 sends 0x55, 0xA3 (last on 0xA3) → grant_o=4'b0010; two tx_start_o pulses carrying 0x55 then 0xA3; grant_o=0 after the second busy falls.
- Contention: req 0 and req 2 both valid after reset, each a 1-byte packet → req 0 is served first, then req 2; next simultaneous request from 0 and 2 → req 0 first again (pointer was 2).
- Burst limit: MAX_BURST=8, req 3 streams 10 bytes 0x00..0x09, last on 0x09 → grant drops after 0x07; if req 0 is waiting it is served; req 3 resumes with 0x08 and 0x09.
- Packet lock: req 0 sends 0x11 (not last), drops valid for 50 cycles while req 1 is valid → no tx_start_o, grant_o stays 4'b0001; req 0 sends 0x22 with last → then req 1 is granted.
- Busy interlock: hold tx_busy_i=1 externally while req 2 is valid → no req_ready_o or tx_start_o until busy falls; then exactly one start.
- Reset mid-frame: assert rstb_i low in WAIT_DONE → all outputs are 0 on the same edge; after release, req 0 wins if several requesters are valid.
